// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks A/B through all four combinations of a two-input gate unit and captures a 28-bit truth table.
// Optional golden compare of the captured outputs is enabled by defining GATE_SWEEP_CHECK_EN.
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        drv_A,
    output logic        drv_B,
    input  logic [6:0]  gate_out,
    output logic        busy,
    output logic        done,
    output logic [27:0] tt,
    output logic        err,
    output logic [6:0]  err_mask
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    drv_q, drv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [27:0]   tt_q, tt_d;
    logic          accept, quit, cap;

    assign accept = (state_q == S_IDLE) && start;
    assign quit   = abort && (state_q == S_SETTLE || state_q == S_CAPTURE);
    assign cap    = (state_q == S_CAPTURE) && !abort;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drv_d   = drv_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        if (accept) begin
            state_d = S_SETTLE;
            idx_d   = 2'd0;
            drv_d   = 2'd0;
            cnt_d   = CNT_LOAD;
            tt_d    = '0;
        end else if (quit) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            drv_d   = 2'd0;
        end else if (state_q == S_SETTLE) begin
            cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            state_d = (cnt_q <= CW'(1)) ? S_CAPTURE : S_SETTLE;
        end else if (cap) begin
            tt_d[7*idx_q +: 7] = gate_out;
            state_d = (idx_q == 2'd3) ? S_DONE : S_SETTLE;
            // idx wraps 3->0, which is also the drive value wanted on entry to DONE
            idx_d   = idx_q + 2'd1;
            drv_d   = idx_q + 2'd1;
            cnt_d   = CNT_LOAD;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            drv_q   <= 2'd0;
            cnt_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drv_q   <= drv_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
        end
    end

    assign drv_A = drv_q[1];
    assign drv_B = drv_q[0];
    assign busy  = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done  = (state_q == S_DONE);
    assign tt    = tt_q;

`ifdef GATE_SWEEP_CHECK_EN
    logic [6:0] mask_q, mask_d, exp_out;
    logic       err_q, err_d;
    logic       a, b;

    assign a       = drv_q[1];
    assign b       = drv_q[0];
    assign exp_out = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};

    always_comb begin
        mask_d = accept ? 7'd0 : cap ? (mask_q | (gate_out ^ exp_out)) : mask_q;
        err_d  = accept ? 1'b0 : (cap && idx_q == 2'd3) ? |mask_d : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 7'd0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign err      = err_q;
    assign err_mask = mask_q;
`else
    assign err      = 1'b0;
    assign err_mask = 7'd0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: table vectors, directed corner sequences and randomized runs against a timing-arithmetic model.
module tb_gate_sweep_ctrl;
`ifdef GATE_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int S1 = 1;
    localparam int S3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, abort1, start3, abort3;
    logic [6:0]  stuck;
    logic        a1, b1, busy1, done1, err1;
    logic        a3, b3, busy3, done3, err3;
    logic [6:0]  go1, go3, mask1, mask3;
    logic [27:0] tt1, tt3;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int busy_cnt;

    int          m_phase;
    int          m_t;
    logic [27:0] m_tt;
    logic [6:0]  m_mask;
    logic        m_err;

    typedef struct {
        logic       st;
        logic [1:0] drv;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [6:0] gold(input logic [1:0] k);
        case (k)
            2'd0:    return 7'h5C;
            2'd1:    return 7'h2E;
            2'd2:    return 7'h2A;
            default: return 7'h43;
        endcase
    endfunction

    assign go1 = gold({a1, b1}) & ~stuck;
    assign go3 = gold({a3, b3});

    always #5 clk = ~clk;

    gate_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .drv_A(a1), .drv_B(b1), .gate_out(go1), .busy(busy1), .done(done1),
        .tt(tt1), .err(err1), .err_mask(mask1)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(S3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .drv_A(a3), .drv_B(b3), .gate_out(go3), .busy(busy3), .done(done3),
        .tt(tt3), .err(err3), .err_mask(mask3)
    );

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_tt    = '0;
        m_mask  = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic ab);
        int p;
        int k;
        logic [6:0] cv;
        p = S1 + 1;
        if (m_phase == 1) begin
            if (ab) m_phase = 0;
            else begin
                m_t++;
                if (m_t % p == 0) begin
                    k = m_t / p - 1;
                    cv = gold(2'(k)) & ~stuck;
                    m_tt[7*k +: 7] = cv;
                    m_mask = m_mask | (cv ^ gold(2'(k)));
                    if (m_t == 4 * p) begin
                        m_phase = 2;
                        m_err = |m_mask;
                    end
                end
            end
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (st) begin
            m_phase = 1;
            m_t     = 0;
            m_tt    = '0;
            m_mask  = '0;
            m_err   = 1'b0;
        end
    endtask

    task automatic step(input logic st, input logic ab);
        start1 = st;
        abort1 = ab;
        @(posedge clk);
        model_step(st, ab);
        #1;
        if (done1) done_cnt++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_drv"},  {26'd0, a1, b1}, (m_phase == 1) ? 28'(m_t / (S1 + 1)) : 28'd0);
        chk({tag, "_busy"}, busy1, m_phase == 1);
        chk({tag, "_done"}, done1, m_phase == 2);
        chk({tag, "_tt"},   tt1, m_tt);
        chk({tag, "_err"},  err1, CHK & m_err);
        chk({tag, "_mask"}, mask1, CHK ? m_mask : 7'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0};

        rst = 1'b1; start1 = 0; abort1 = 0; start3 = 0; abort3 = 0; stuck = '0;
        model_reset();
        #3;
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_drv", {a1, b1}, 2'b00);
        chk("rst_tt", tt1, 28'd0);
        chk("rst_err", {err1, mask1}, 8'd0);
        #9 rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].st, 1'b0);
            chk($sformatf("tbl%0d_drv", i), {a1, b1}, tbl[i].drv);
            chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done1, tbl[i].done);
        end
        chk("good_tt", tt1, 28'h86A975C);
        chk("good_err", err1, 1'b0);
        chk("good_mask", mask1, 7'd0);
        chk("one_done", done_cnt, 1);

        stuck = 7'h01;
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("stuck_done", done1, 1'b1);
        chk("stuck_slice3", tt1[27:21], 7'h42);
        chk("stuck_tt", tt1, 28'h84A975C);
        chk("stuck_mask", mask1, CHK ? 7'h01 : 7'h00);
        chk("stuck_err", err1, CHK);
        step(1'b0, 1'b0);
        chk("stuck_err_hold", err1, CHK);
        stuck = '0;

        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk("pre_abort_drv", {a1, b1}, 2'b10);
        step(1'b1, 1'b1);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_drv", {a1, b1}, 2'b00);
        chk("abort_tt", tt1, 28'h000175C);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("abort_no_done", done1, 1'b0);
        end
        chk("done_count_abort", done_cnt, 2);

        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        busy_cnt = busy3 ? 1 : 0;
        chk("s3_drv_0", {a3, b3}, 2'b00);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 1'b0);
            if (busy3) busy_cnt++;
            chk($sformatf("s3_drv_%0d", k), {a3, b3}, (k < 16) ? 2'(k / 4) : 2'b00);
            chk($sformatf("s3_done_%0d", k), done3, k == 16);
        end
        chk("s3_busy_cycles", busy_cnt, 16);
        chk("s3_tt", tt3, 28'h86A975C);

        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("pre_rst_tt", tt1[6:0], 7'h5C);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy1, 1'b0);
        chk("arst_drv", {a1, b1}, 2'b00);
        chk("arst_tt", tt1, 28'd0);
        chk("arst_done", done1, 1'b0);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("post_rst_done", done1, 1'b1);
        chk("post_rst_tt", tt1, 28'h86A975C);
        step(1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) stuck = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
